// File: rtl/fpu_pkg.sv
// fpu_pkg: opcodes, response status codes and sequencer state encoding shared by the FPU command path.
package fpu_pkg;

    localparam logic [7:0] FPU_ADD = 8'd0;
    localparam logic [7:0] FPU_SUB = 8'd1;
    localparam logic [7:0] FPU_MLT = 8'd2;
    localparam logic [7:0] FPU_DIV = 8'd3;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_ILLEGAL = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_ABORT = 2'd3;

    function automatic logic op_legal(input logic [7:0] op);
        return op inside {FPU_ADD, FPU_SUB, FPU_MLT, FPU_DIV};
    endfunction

endpackage

// File: rtl/fpu_cmd_fifo.sv
// fpu_cmd_fifo: synchronous command FIFO; extra pointer bit separates full from empty, no write-to-read bypass.
module fpu_cmd_fifo #(
    parameter int W     = 76,
    parameter int DEPTH = 4
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wp;
    logic [AW:0]  rp;

    assign empty = wp == rp;
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign rdata = mem[rp[AW-1:0]];

    always_ff @(posedge Clock) begin
        if (push && !full) mem[wp[AW-1:0]] <= wdata;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push && !full) wp <= wp + (AW+1)'(1);
            if (pop && !empty) rp <= rp + (AW+1)'(1);
        end
    end

endmodule

// File: rtl/fpu_op_sequencer.sv
// fpu_op_sequencer: queues tagged FP commands, issues them one at a time to the FPU op unit and returns tagged results.
module fpu_op_sequencer
    import fpu_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 256
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             InValid,
    output logic             InReady,
    input  logic [31:0]      InLhs,
    input  logic [31:0]      InRhs,
    input  logic [7:0]       InOp,
    input  logic [TAG_W-1:0] InTag,
    output logic             FpuTrigger,
    input  logic             FpuCompleted,
    output logic [31:0]      FpuLhs,
    output logic [31:0]      FpuRhs,
    output logic [7:0]       FpuOp,
    input  logic [31:0]      FpuResult,
    output logic             FpuReset,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [31:0]      OutResult,
    output logic [TAG_W-1:0] OutTag,
    output logic [1:0]       OutStatus,
    output logic             Busy
);
    localparam int W  = 72 + TAG_W;
    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    logic [1:0]       state;
    logic [TW-1:0]    timer;
    logic [TAG_W-1:0] tag_r;
    logic [W-1:0]     head;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    wire [31:0]      h_rhs = head[31:0];
    wire [31:0]      h_lhs = head[63:32];
    wire [7:0]       h_op  = head[71:64];
    wire [TAG_W-1:0] h_tag = head[W-1:72];

    assign InReady    = !full;
    assign push       = InValid && !full;
    assign pop        = (state == S_IDLE) && !empty && (!OutValid || OutReady);
    assign FpuTrigger = state == S_ISSUE;
    assign FpuReset   = Reset || (state == S_ABORT);
    assign Busy       = (state != S_IDLE) || !empty;

    fpu_cmd_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
        .Clock (Clock),
        .Reset (Reset),
        .push  (push),
        .pop   (pop),
        .wdata ({InTag, InOp, InLhs, InRhs}),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    // Operand registers load only on pop, keeping them stable for the FPU's op-muxed result.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= S_IDLE;
            timer     <= '0;
            tag_r     <= '0;
            FpuLhs    <= '0;
            FpuRhs    <= '0;
            FpuOp     <= '0;
            OutValid  <= 1'b0;
            OutResult <= '0;
            OutTag    <= '0;
            OutStatus <= ST_OK;
        end else begin
            if (OutValid && OutReady) OutValid <= 1'b0;
            case (state)
                S_IDLE: if (pop) begin
                    FpuLhs <= h_lhs;
                    FpuRhs <= h_rhs;
                    FpuOp  <= h_op;
                    tag_r  <= h_tag;
                    if (!op_legal(h_op)) begin
                        OutValid  <= 1'b1;
                        OutResult <= '0;
                        OutStatus <= ST_ILLEGAL;
                        OutTag    <= h_tag;
                    end else state <= S_ISSUE;
                end
                S_ISSUE: begin
                    timer <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    timer <= &timer ? timer : timer + TW'(1);
                    if (FpuCompleted) begin
                        OutValid  <= 1'b1;
                        OutResult <= FpuResult;
                        OutStatus <= ST_OK;
                        OutTag    <= tag_r;
                        state     <= S_IDLE;
                    end else if (timer == T_LAST) begin
                        OutValid  <= 1'b1;
                        OutResult <= '0;
                        OutStatus <= ST_TIMEOUT;
                        OutTag    <= tag_r;
                        state     <= S_ABORT;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// tb_fpu_op_sequencer: directed bench driving the sequencer against a stub FPU with programmable latency.
module tb_fpu_op_sequencer;
    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        InValid = 1'b0;
    logic        InReady;
    logic [31:0] InLhs = '0;
    logic [31:0] InRhs = '0;
    logic [7:0]  InOp = '0;
    logic [3:0]  InTag = '0;
    logic        FpuTrigger;
    logic        FpuCompleted;
    logic [31:0] FpuLhs;
    logic [31:0] FpuRhs;
    logic [7:0]  FpuOp;
    logic [31:0] FpuResult;
    logic        FpuReset;
    logic        OutValid;
    logic        OutReady = 1'b0;
    logic [31:0] OutResult;
    logic [3:0]  OutTag;
    logic [1:0]  OutStatus;
    logic        Busy;

    int checks = 0;
    int errors = 0;
    int lat = 0;
    int cnt = 0;
    logic man_done = 1'b0;
    logic [31:0] rq_res[$];
    logic [3:0]  rq_tag[$];
    logic [1:0]  rq_st[$];
    int trig_cnt = 0;
    int frst_cnt = 0;
    int cyc = 0;
    int last_done = -100;
    logic inf = 1'b0;
    logic [71:0] cap = '0;

    always #5 Clock = ~Clock;

    fpu_op_sequencer #(.DEPTH(4), .TAG_W(4), .TIMEOUT(64)) dut (
        .Clock(Clock), .Reset(Reset),
        .InValid(InValid), .InReady(InReady), .InLhs(InLhs), .InRhs(InRhs), .InOp(InOp), .InTag(InTag),
        .FpuTrigger(FpuTrigger), .FpuCompleted(FpuCompleted), .FpuLhs(FpuLhs), .FpuRhs(FpuRhs),
        .FpuOp(FpuOp), .FpuResult(FpuResult), .FpuReset(FpuReset),
        .OutValid(OutValid), .OutReady(OutReady), .OutResult(OutResult), .OutTag(OutTag),
        .OutStatus(OutStatus), .Busy(Busy)
    );

    // Stub FPU: known single-precision vectors return their true result, anything else returns lhs^rhs.
    function automatic logic [31:0] fpu_model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op == 8'd0 && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
        if (op == 8'd1 && a == 32'h3F800000 && b == 32'h40000000) return 32'hBF800000;
        if (op == 8'd2 && a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
        return a ^ b;
    endfunction

    assign FpuResult    = fpu_model(FpuOp, FpuLhs, FpuRhs);
    assign FpuCompleted = (cnt == 1) || man_done;

    always @(posedge Clock) begin
        if (FpuReset) cnt <= 0;
        else if (FpuTrigger) cnt <= lat;
        else if (cnt > 0) cnt <= cnt - 1;
    end

    always @(posedge Clock) begin
        cyc++;
        if (!Reset) begin
            if (OutValid && OutReady) begin
                rq_res.push_back(OutResult);
                rq_tag.push_back(OutTag);
                rq_st.push_back(OutStatus);
            end
            if (FpuReset) frst_cnt++;
            if (FpuTrigger) begin
                trig_cnt++;
                checks++;
                assert (cyc - last_done >= 2) else begin
                    errors++;
                    $error("FAIL trigger_gap observed %0d required >=2", cyc - last_done);
                end
            end
            if (FpuCompleted) last_done = cyc;
        end
        if (FpuReset) inf = 1'b0;
        else if (FpuTrigger) begin
            inf = 1'b1;
            cap = {FpuLhs, FpuRhs, FpuOp};
        end else if (inf) begin
            checks++;
            assert ({FpuLhs, FpuRhs, FpuOp} === cap) else begin
                errors++;
                $error("FAIL operand_stable observed %h required %h", {FpuLhs, FpuRhs, FpuOp}, cap);
            end
            if (FpuCompleted) inf = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_resp(input int i, input logic [31:0] res, input logic [3:0] tag, input logic [1:0] st);
        check("resp_result", (i < rq_res.size()) ? rq_res[i] : 32'hDEAD_DEAD, res);
        check("resp_tag", (i < rq_tag.size()) ? 32'(rq_tag[i]) : 32'hDEAD_DEAD, 32'(tag));
        check("resp_status", (i < rq_st.size()) ? 32'(rq_st[i]) : 32'hDEAD_DEAD, 32'(st));
    endtask

    task automatic wait_resps(input int n);
        int k;
        k = 0;
        while (rq_res.size() < n && k < 300) begin
            @(negedge Clock);
            k++;
        end
        check("resp_count", 32'(rq_res.size()), 32'(n));
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [7:0] op, input logic [3:0] tag,
                        output logic ok);
        InValid = 1'b1;
        InLhs = a;
        InRhs = b;
        InOp = op;
        InTag = tag;
        ok = InReady;
        @(negedge Clock);
        InValid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        int t0;
        int f0;
        int k;
        int n;
        logic ok;
        repeat (3) @(negedge Clock);
        Reset = 1'b0;
        check("rst_in_ready", 32'(InReady), 1);
        check("rst_out_valid", 32'(OutValid), 0);
        check("rst_trigger", 32'(FpuTrigger), 0);
        check("rst_busy", 32'(Busy), 0);
        check("rst_fpu_lhs", FpuLhs, 0);
        check("rst_fpu_rhs", FpuRhs, 0);
        check("rst_fpu_op", 32'(FpuOp), 0);
        check("rst_out_result", OutResult, 0);
        check("rst_out_tag", 32'(OutTag), 0);
        check("rst_out_status", 32'(OutStatus), 0);

        // 1: single ADD
        OutReady = 1'b1;
        lat = 3;
        t0 = trig_cnt;
        b = rq_res.size();
        push(32'h3F800000, 32'h40000000, 8'd0, 4'd5, ok);
        check("t1_accept", 32'(ok), 1);
        wait_resps(b + 1);
        repeat (4) @(negedge Clock);
        check("t1_triggers", 32'(trig_cnt - t0), 1);
        check_resp(b, 32'h40400000, 4'd5, 2'b00);

        // 2: SUB then MLT, in order
        lat = 4;
        b = rq_res.size();
        push(32'h3F800000, 32'h40000000, 8'd1, 4'd1, ok);
        push(32'h40000000, 32'h40400000, 8'd2, 4'd2, ok);
        wait_resps(b + 2);
        check_resp(b, 32'hBF800000, 4'd1, 2'b00);
        check_resp(b + 1, 32'h40C00000, 4'd2, 2'b00);
        repeat (3) @(negedge Clock);

        // 3: illegal opcode, then a normal ADD
        t0 = trig_cnt;
        b = rq_res.size();
        push(32'h12345678, 32'h9ABCDEF0, 8'd7, 4'd3, ok);
        k = 0;
        while (!OutValid && k < 4) begin
            @(negedge Clock);
            k++;
        end
        check("t3_valid_latency", 32'(k), 1);
        wait_resps(b + 1);
        check("t3_no_trigger", 32'(trig_cnt - t0), 0);
        check_resp(b, 32'h0, 4'd3, 2'b01);
        push(32'h3F800000, 32'h40000000, 8'd0, 4'd4, ok);
        wait_resps(b + 2);
        check_resp(b + 1, 32'h40400000, 4'd4, 2'b00);
        repeat (3) @(negedge Clock);

        // 4: backpressure fills one capture plus four FIFO entries
        OutReady = 1'b0;
        lat = 2;
        b = rq_res.size();
        for (int i = 0; i < 7; i++) begin
            push(32'h10000000 + i, 32'h00000100, 8'd0, 4'(8 + i), ok);
            check("t4_accept", 32'(ok), (i < 5) ? 1 : 0);
        end
        check("t4_in_ready", 32'(InReady), 0);
        check("t4_busy", 32'(Busy), 1);
        check("t4_held_valid", 32'(OutValid), 1);
        check("t4_held_tag", 32'(OutTag), 8);
        OutReady = 1'b1;
        wait_resps(b + 5);
        repeat (20) @(negedge Clock);
        check("t4_no_dup", 32'(rq_res.size()), 32'(b + 5));
        for (int i = 0; i < 5; i++) check_resp(b + i, 32'h10000100 + i, 4'(8 + i), 2'b00);

        // 5: hung FPU times out, next queued op still completes
        OutReady = 1'b0;
        lat = 0;
        b = rq_res.size();
        f0 = frst_cnt;
        push(32'h3F800000, 32'h40000000, 8'd0, 4'd1, ok);
        push(32'h3F800000, 32'h40000000, 8'd1, 4'd2, ok);
        k = 0;
        while (!FpuTrigger && k < 20) begin
            @(negedge Clock);
            k++;
        end
        check("t5_trigger_seen", 32'(FpuTrigger), 1);
        n = 0;
        @(negedge Clock);
        while (!OutValid && n < 200) begin
            n++;
            @(negedge Clock);
        end
        check("t5_wait_cycles", 32'(n), 64);
        check("t5_abort_pulse", 32'(FpuReset), 1);
        check("t5_status", 32'(OutStatus), 32'b10);
        check("t5_result", OutResult, 0);
        check("t5_tag", 32'(OutTag), 1);
        lat = 3;
        @(negedge Clock);
        check("t5_abort_end", 32'(FpuReset), 0);
        check("t5_abort_count", 32'(frst_cnt - f0), 1);
        OutReady = 1'b1;
        wait_resps(b + 2);
        check_resp(b, 32'h0, 4'd1, 2'b10);
        check_resp(b + 1, 32'hBF800000, 4'd2, 2'b00);
        repeat (3) @(negedge Clock);

        // 6: reset mid-WAIT with two commands queued
        lat = 0;
        b = rq_res.size();
        t0 = trig_cnt;
        push(32'h00000011, 32'h00000022, 8'd0, 4'd4, ok);
        push(32'h00000033, 32'h00000044, 8'd0, 4'd5, ok);
        push(32'h00000055, 32'h00000066, 8'd0, 4'd6, ok);
        @(negedge Clock);
        check("t6_busy_before", 32'(Busy), 1);
        check("t6_one_issue", 32'(trig_cnt - t0), 1);
        Reset = 1'b1;
        #1;
        check("t6_fpu_reset", 32'(FpuReset), 1);
        @(negedge Clock);
        Reset = 1'b0;
        #1;
        check("t6_out_valid", 32'(OutValid), 0);
        check("t6_in_ready", 32'(InReady), 1);
        check("t6_busy", 32'(Busy), 0);
        check("t6_trigger", 32'(FpuTrigger), 0);
        @(negedge Clock);
        man_done = 1'b1;
        @(negedge Clock);
        man_done = 1'b0;
        repeat (5) @(negedge Clock);
        check("t6_late_ignored", 32'(OutValid), 0);
        check("t6_idle", 32'(Busy), 0);
        check("t6_no_resp", 32'(rq_res.size()), 32'(b));
        check("t6_no_reissue", 32'(trig_cnt - t0), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
